operand_sequencer: RTL and testbench
====================================

Name: operand_sequencer

Overview:
- Drives the register file's control side: it is the initiator for the register file's autoincrement, PC-increment and operand interfaces.
- For each decoded Format I/II instruction, it resolves the MSP430 source and destination addressing modes.
- It fetches extension words and memory operands over the data bus and issues incPC/incSrc pulses.
- It hands resolved src/dst operand values and the dst effective address to the execute stage.

Parameters:
- ADDR_W, 16, memory address width (64 KB space)
- DATA_W, 16, register/memory word width

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse; latch instruction fields below
- As  in  2  source addressing mode
- Ad  in  1  destination addressing mode
- BW  in  1  1 = byte operation
- srcA  in  4  source register number
- dstA  in  4  destination register number
- needSrc  in  1  0 for Format II single-operand (skip src phase)
- readDst  in  1  1 = destination memory operand must be read (0 for MOV)
- srcData  in  16  register file read of srcA
- dstData  in  16  register file read of dstA
- PC  in  16  current program counter
- memRData  in  16  memory read data, valid the cycle after memRE
- memRE  out  1  memory read strobe
- memAddr  out  16  word-aligned read address
- incPC  out  1  one-cycle pulse; register file adds 2 to PC
- incSrc  out  1  one-cycle pulse; register file autoincrements srcA
- srcOp  out  16  resolved source operand
- dstOp  out  16  resolved destination operand (register value or memory value)
- dstEA  out  16  destination effective address (valid when dstMem = 1)
- dstMem  out  1  destination is in memory
- busy  out  1  high from the cycle after start until done
- done  out  1  one-cycle pulse; all outputs valid

Behaviour:
- Reset: state IDLE; all outputs 0.
- start while busy = 1 is ignored.
- FSM states: IDLE, S_EXT, S_EXTW, S_RD, S_RDW, D_EXT, D_EXTW, D_RD, D_RDW, DONE.
  - Each memory access is two cycles. The *_EXT / *_RD state asserts memRE with memAddr. The *W state captures memRData.
  - IDLE + start goes to the src phase if needSrc = 1, otherwise to the dst phase.
- Src constant generator: no memory access, 0 extra cycles.
  - R3: As = 00/01/10/11 gives 0, 1, 2, 0xFFFF.
  - R2: As = 10 gives 4; As = 11 gives 8.
- Src register mode (As = 00, not CG): srcOp = srcData.
- Src As = 01 (indexed):
  - S_EXT reads at PC and pulses incPC in the S_EXTW cycle.
  - EA = X + srcData, or EA = X for R2 (absolute &ADDR).
  - Then S_RD at EA.
- Src As = 10: S_RD at srcData.
- Src As = 11:
  - If srcA = PC (immediate): S_RD at PC, pulse incPC.
  - Otherwise: S_RD at srcData, pulse incSrc in the S_RDW cycle. The register file adds 1 if BW and srcA ∉ {PC, SP}, otherwise 2.
- Dst Ad = 0: dstOp = dstData, dstMem = 0, no memory cycles.
- Dst Ad = 1:
  - D_EXT reads the extension word at PC (after any src incPC) and pulses incPC.
  - dstEA = X + dstData, or X for R2.
  - Then D_RD at dstEA only if readDst = 1. dstMem = 1.
- Byte rule:
  - memAddr[0] is always 0.
  - When BW = 1, the memory operand is memRData[15:8] if EA[0] = 1, otherwise memRData[7:0]; it is zero-extended.
  - Register operands are masked to [7:0] when BW = 1.
- Address arithmetic: 16-bit, wraps modulo 2^16 (e.g. 0xFFFE + 4 = 0x0002).
- Ordering:
  - incPC/incSrc never pulse in the same cycle.
  - A src ext fetch always precedes a dst ext fetch.
- done pulses in DONE, then the FSM returns to IDLE. Outputs hold their values until the next start.
- Latency (start to done): register/register = 2 cycles; each memory access adds 2.
- Reset mid-sequence: abort immediately, with no incPC/incSrc in the reset cycle.

Decomposition:
- Shared package (RegisterParams include): register indices PC = 0, SP = 1, SR = 2, CG2 = 3; As encodings; CG constant values; FSM state encoding.
- One sub-module, operand_cg: combinational constant-generator decode (srcA, As → hit, value).

Test Plan:
- MOV R5, R6 (As = 00, Ad = 0), R5 = 0x1234 → done 2 cycles after start; srcOp = 0x1234; no memRE/incPC.
- ADD #0x00AA, R4 (As = 11, srcA = PC = 0xC000), memRData = 0x00AA → memRE at memAddr 0xC000; one incPC; srcOp = 0x00AA.
- MOV.B @R7+, R8, R7 = 0x2001, mem[0x2000] = 0xBEEF → memAddr 0x2000; srcOp = 0x00BE; one incSrc.
- ADD 4(R9), 2(R10), R9 = 0x3000, R10 = 0x4000 → reads in order: PC ext, 0x3004, PC+2 ext, 0x4002; two incPC; dstEA = 0x4002; dstMem = 1.
- MOV #-1 (R3, As = 11), &0x0200 (Ad = 1, dstA = R2, readDst = 0) → srcOp = 0xFFFF; one memory read (ext word); dstEA = 0x0200.
- reset asserted during S_RDW → next cycle IDLE; busy = 0; no done; no incSrc pulse.

Source files
------------

// File: rtl/operand_sequencer_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : operand_sequencer_pkg
//  Purpose  : Shared definitions for the operand sequencer: register indices,
//             source addressing-mode encodings, constant-generator values,
//             FSM state encoding and the latched instruction-field record.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package operand_sequencer_pkg;

    // Register file indices with architectural meaning
    localparam logic [3:0] REG_PC  = 4'd0;
    localparam logic [3:0] REG_SP  = 4'd1;
    localparam logic [3:0] REG_SR  = 4'd2;
    localparam logic [3:0] REG_CG2 = 4'd3;

    // Source addressing modes (As field)
    localparam logic [1:0] AS_REG = 2'b00;  // Rn
    localparam logic [1:0] AS_IDX = 2'b01;  // X(Rn)
    localparam logic [1:0] AS_IND = 2'b10;  // @Rn
    localparam logic [1:0] AS_INC = 2'b11;  // @Rn+ / #imm

    // Constant-generator values
    localparam logic [15:0] CG_ZERO  = 16'h0000;
    localparam logic [15:0] CG_ONE   = 16'h0001;
    localparam logic [15:0] CG_TWO   = 16'h0002;
    localparam logic [15:0] CG_ALL1  = 16'hFFFF;
    localparam logic [15:0] CG_FOUR  = 16'h0004;
    localparam logic [15:0] CG_EIGHT = 16'h0008;

    // FSM state encoding
    localparam int         ST_W      = 4;
    localparam logic [3:0] ST_IDLE   = 4'd0;
    localparam logic [3:0] ST_S_EXT  = 4'd1;
    localparam logic [3:0] ST_S_EXTW = 4'd2;
    localparam logic [3:0] ST_S_RD   = 4'd3;
    localparam logic [3:0] ST_S_RDW  = 4'd4;
    localparam logic [3:0] ST_D_EXT  = 4'd5;
    localparam logic [3:0] ST_D_EXTW = 4'd6;
    localparam logic [3:0] ST_D_RD   = 4'd7;
    localparam logic [3:0] ST_D_RDW  = 4'd8;
    localparam logic [3:0] ST_DONE   = 4'd9;

    // Instruction fields captured at start and held for the whole sequence
    typedef struct packed {
        logic [1:0] as_mode;
        logic       ad;
        logic       bw;
        logic [3:0] src_a;
        logic [3:0] dst_a;
        logic       read_dst;
    } instr_t;

endpackage : operand_sequencer_pkg
`default_nettype wire

// File: rtl/operand_sequencer_cg.sv
`default_nettype none
// ============================================================================
//  Module   : operand_cg
//  Purpose  : Combinational constant-generator decode. R3 yields 0/1/2/-1 for
//             every As; R2 yields 4/8 for the two indirect encodings only
//             (R2 register and indexed modes are ordinary/absolute accesses).
//  Ports    : src_a   [3:0] in  - source register number
//             as_mode [1:0] in  - source addressing mode
//             hit           out - source is a generated constant
//             value  [15:0] out - generated constant (0 when no hit)
//  Revision : 1.0 - initial release
// ============================================================================
module operand_cg
    import operand_sequencer_pkg::*;
(
    input  logic [3:0]  src_a,
    input  logic [1:0]  as_mode,
    output logic        hit,
    output logic [15:0] value
);

    always_comb begin
        hit   = 1'b0;
        value = CG_ZERO;
        if (src_a == REG_CG2) begin
            hit = 1'b1;
            case (as_mode)
                AS_REG:  value = CG_ZERO;
                AS_IDX:  value = CG_ONE;
                AS_IND:  value = CG_TWO;
                default: value = CG_ALL1;
            endcase
        end else if (src_a == REG_SR) begin
            if (as_mode == AS_IND) begin
                hit   = 1'b1;
                value = CG_FOUR;
            end else if (as_mode == AS_INC) begin
                hit   = 1'b1;
                value = CG_EIGHT;
            end
        end
    end

endmodule : operand_cg
`default_nettype wire

// File: rtl/operand_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : operand_sequencer
//  Purpose  : Resolves MSP430 Format I/II source and destination operands.
//             Fetches extension words and memory operands (two cycles per
//             access), issues PC-increment and source-autoincrement pulses to
//             the register file, and presents srcOp/dstOp/dstEA to execute.
//  Ports    : clk, reset              - clock, synchronous active-high reset
//             start, As, Ad, BW, srcA, dstA, needSrc, readDst
//                                     - instruction fields, latched on start
//             srcData, dstData, PC    - register file read values
//             memRData                - memory data, valid cycle after memRE
//             memRE, memAddr          - memory read strobe / aligned address
//             incPC, incSrc           - register file update pulses
//             srcOp, dstOp, dstEA, dstMem - resolved operands
//             busy, done              - sequencing status
//  Revision : 1.0 - initial release
// ============================================================================
module operand_sequencer
    import operand_sequencer_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [1:0]        As,
    input  logic              Ad,
    input  logic              BW,
    input  logic [3:0]        srcA,
    input  logic [3:0]        dstA,
    input  logic              needSrc,
    input  logic              readDst,
    input  logic [DATA_W-1:0] srcData,
    input  logic [DATA_W-1:0] dstData,
    input  logic [ADDR_W-1:0] PC,
    input  logic [DATA_W-1:0] memRData,
    output logic              memRE,
    output logic [ADDR_W-1:0] memAddr,
    output logic              incPC,
    output logic              incSrc,
    output logic [DATA_W-1:0] srcOp,
    output logic [DATA_W-1:0] dstOp,
    output logic [ADDR_W-1:0] dstEA,
    output logic              dstMem,
    output logic              busy,
    output logic              done
);

    // ------------------------------------------------------------------
    // Operand formatting helpers
    // ------------------------------------------------------------------
    // Register operands of byte instructions use only the low byte.
    function automatic logic [DATA_W-1:0] reg_operand(input logic [DATA_W-1:0] word,
                                                      input logic              bw);
        return bw ? {{(DATA_W-8){1'b0}}, word[7:0]} : word;
    endfunction

    // Memory words are always fetched aligned; for byte access the odd
    // address selects the high byte.
    function automatic logic [DATA_W-1:0] mem_operand(input logic [DATA_W-1:0] word,
                                                      input logic              odd,
                                                      input logic              bw);
        if (!bw)
            return word;
        return odd ? {{(DATA_W-8){1'b0}}, word[15:8]}
                   : {{(DATA_W-8){1'b0}}, word[7:0]};
    endfunction

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    logic [ST_W-1:0]   r_state;
    instr_t            r_fld;
    logic [ADDR_W-1:0] r_src_ea;
    logic [DATA_W-1:0] r_src_op;
    logic [DATA_W-1:0] r_dst_op;
    logic [ADDR_W-1:0] r_dst_ea;
    logic              r_dst_mem;
    logic              r_done;

    instr_t            w_in_fld;
    instr_t            w_fld;
    logic              w_cg_hit;
    logic [15:0]       w_cg_val;
    logic              w_src_no_mem;
    logic              w_enter_dst;
    logic              w_src_imm;
    logic [ADDR_W-1:0] w_rd_addr;

    always_comb begin
        w_in_fld          = '0;
        w_in_fld.as_mode  = As;
        w_in_fld.ad       = Ad;
        w_in_fld.bw       = BW;
        w_in_fld.src_a    = srcA;
        w_in_fld.dst_a    = dstA;
        w_in_fld.read_dst = readDst;
    end

    // In IDLE the decision is made from the live inputs; afterwards from the
    // fields captured at start.
    assign w_fld = (r_state == ST_IDLE) ? w_in_fld : r_fld;

    operand_cg u_cg (
        .src_a   (w_fld.src_a),
        .as_mode (w_fld.as_mode),
        .hit     (w_cg_hit),
        .value   (w_cg_val)
    );

    // Source resolved without any memory traffic (constant or register)
    assign w_src_no_mem = w_cg_hit || (w_fld.as_mode == AS_REG);

    // @PC+ is the immediate form: the word at PC is the operand itself
    assign w_src_imm = (r_fld.as_mode == AS_INC) && (r_fld.src_a == REG_PC);

    // Cycles in which the sequence moves on to the destination phase
    assign w_enter_dst = ((r_state == ST_IDLE) && start && (!needSrc || w_src_no_mem))
                       || (r_state == ST_S_RDW);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_fld     <= '0;
            r_src_ea  <= '0;
            r_src_op  <= '0;
            r_dst_op  <= '0;
            r_dst_ea  <= '0;
            r_dst_mem <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_fld <= w_in_fld;
                        if (!needSrc) begin
                            r_src_op <= '0;
                        end else if (w_cg_hit) begin
                            r_src_op <= reg_operand(DATA_W'(w_cg_val), BW);
                        end else begin
                            case (As)
                                AS_REG: r_src_op <= reg_operand(srcData, BW);
                                AS_IDX: r_state  <= ST_S_EXT;
                                AS_IND: begin
                                    r_src_ea <= ADDR_W'(srcData);
                                    r_state  <= ST_S_RD;
                                end
                                default: begin
                                    r_src_ea <= (srcA == REG_PC) ? PC : ADDR_W'(srcData);
                                    r_state  <= ST_S_RD;
                                end
                            endcase
                        end
                    end
                end
                ST_S_EXT:  r_state <= ST_S_EXTW;
                ST_S_EXTW: begin
                    // &ADDR: R2 as base contributes nothing to the address
                    r_src_ea <= ADDR_W'(memRData)
                              + ((r_fld.src_a == REG_SR) ? '0 : ADDR_W'(srcData));
                    r_state  <= ST_S_RD;
                end
                ST_S_RD:   r_state <= ST_S_RDW;
                ST_S_RDW:  r_src_op <= mem_operand(memRData, r_src_ea[0], r_fld.bw);
                ST_D_EXT:  r_state <= ST_D_EXTW;
                ST_D_EXTW: begin
                    r_dst_ea <= ADDR_W'(memRData)
                              + ((r_fld.dst_a == REG_SR) ? '0 : ADDR_W'(dstData));
                    if (r_fld.read_dst) begin
                        r_state <= ST_D_RD;
                    end else begin
                        r_dst_op <= '0;
                        r_state  <= ST_DONE;
                    end
                end
                ST_D_RD:   r_state <= ST_D_RDW;
                ST_D_RDW: begin
                    r_dst_op <= mem_operand(memRData, r_dst_ea[0], r_fld.bw);
                    r_state  <= ST_DONE;
                end
                ST_DONE: begin
                    r_done  <= 1'b1;
                    r_state <= ST_IDLE;
                end
                default:   r_state <= ST_IDLE;
            endcase

            // Destination phase entry overrides the next state chosen above
            if (w_enter_dst) begin
                if (w_fld.ad) begin
                    r_dst_mem <= 1'b1;
                    r_state   <= ST_D_EXT;
                end else begin
                    r_dst_op  <= reg_operand(dstData, w_fld.bw);
                    r_dst_ea  <= '0;
                    r_dst_mem <= 1'b0;
                    r_state   <= ST_DONE;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs. Strobes are gated by reset so an aborted sequence never
    // updates the register file in the reset cycle.
    // ------------------------------------------------------------------
    always_comb begin
        w_rd_addr = '0;
        case (r_state)
            ST_S_EXT, ST_D_EXT: w_rd_addr = PC;
            ST_S_RD:            w_rd_addr = r_src_ea;
            ST_D_RD:            w_rd_addr = r_dst_ea;
            default:            w_rd_addr = '0;
        endcase
    end

    assign memRE   = !reset && ((r_state == ST_S_EXT) || (r_state == ST_S_RD)
                              || (r_state == ST_D_EXT) || (r_state == ST_D_RD));
    assign memAddr = memRE ? {w_rd_addr[ADDR_W-1:1], 1'b0} : '0;

    assign incPC   = !reset && ((r_state == ST_S_EXTW) || (r_state == ST_D_EXTW)
                              || ((r_state == ST_S_RDW) && w_src_imm));
    assign incSrc  = !reset && (r_state == ST_S_RDW)
                   && (r_fld.as_mode == AS_INC) && !w_src_imm;

    assign srcOp   = r_src_op;
    assign dstOp   = r_dst_op;
    assign dstEA   = r_dst_ea;
    assign dstMem  = r_dst_mem;
    assign busy    = !reset && (r_state != ST_IDLE);
    assign done    = r_done;

endmodule : operand_sequencer
`default_nettype wire

// File: tb/tb_operand_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_operand_sequencer
//  Purpose  : Self-checking bench for operand_sequencer. A transaction-level
//             model predicts the ordered memory reads, pulse counts, latency
//             and final operands of each instruction; directed cases pin the
//             model with literal values, then randomized instructions follow.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_operand_sequencer;

    logic        clk = 1'b0;
    logic        reset, start;
    logic [1:0]  As;
    logic        Ad, BW, needSrc, readDst;
    logic [3:0]  srcA, dstA;
    logic [15:0] srcData, dstData, PC, memRData;
    logic        memRE, incPC, incSrc, dstMem, busy, done;
    logic [15:0] memAddr, srcOp, dstOp, dstEA;

    always #5 clk = ~clk;

    operand_sequencer #(.ADDR_W(16), .DATA_W(16)) dut (
        .clk(clk), .reset(reset), .start(start), .As(As), .Ad(Ad), .BW(BW),
        .srcA(srcA), .dstA(dstA), .needSrc(needSrc), .readDst(readDst),
        .srcData(srcData), .dstData(dstData), .PC(PC), .memRData(memRData),
        .memRE(memRE), .memAddr(memAddr), .incPC(incPC), .incSrc(incSrc),
        .srcOp(srcOp), .dstOp(dstOp), .dstEA(dstEA), .dstMem(dstMem),
        .busy(busy), .done(done)
    );

    int checks = 0;
    int errors = 0;

    // Memory image: explicit words for directed cases, a fixed hash elsewhere
    logic [15:0] mem_ovr [int];
    logic [15:0] mem_salt;

    function automatic logic [15:0] mem_rd(input logic [15:0] a);
        if (mem_ovr.exists(int'(a)))
            return mem_ovr[int'(a)];
        return ({a[7:0], a[15:8]} ^ mem_salt) + a;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Instruction-level model
    // ------------------------------------------------------------------
    logic [15:0] exp_reads[$];
    logic [15:0] exp_src_op, exp_dst_op, exp_dst_ea;
    logic        exp_dst_mem;
    int          exp_inc_pc, exp_inc_src, exp_lat;
    int          got_pc, got_src, got_lat, got_reads;

    function automatic logic [15:0] bmask(input logic [15:0] v);
        return BW ? (v & 16'h00FF) : v;
    endfunction

    function automatic logic [15:0] pick(input logic [15:0] ea);
        logic [15:0] w;
        w = mem_rd(ea & 16'hFFFE);
        if (!BW) return w;
        return ea[0] ? {8'h00, w[15:8]} : {8'h00, w[7:0]};
    endfunction

    task automatic model();
        logic [15:0] pc, ea;
        pc = PC;
        exp_reads.delete();
        exp_inc_pc  = 0;
        exp_inc_src = 0;
        if (!needSrc) begin
            exp_src_op = 16'h0000;
        end else if (srcA == 4'd3) begin
            exp_src_op = bmask((As == 2'd0) ? 16'h0000 : (As == 2'd1) ? 16'h0001 :
                               (As == 2'd2) ? 16'h0002 : 16'hFFFF);
        end else if (srcA == 4'd2 && As[1]) begin
            exp_src_op = bmask((As == 2'd2) ? 16'h0004 : 16'h0008);
        end else if (As == 2'd0) begin
            exp_src_op = bmask(srcData);
        end else begin
            if (As == 2'd1) begin
                exp_reads.push_back(pc);
                ea = mem_rd(pc) + ((srcA == 4'd2) ? 16'h0000 : srcData);
                pc = pc + 16'd2;
                exp_inc_pc++;
            end else if (As == 2'd3 && srcA == 4'd0) begin
                ea = pc;
                pc = pc + 16'd2;
                exp_inc_pc++;
            end else begin
                ea = srcData;
                if (As == 2'd3) exp_inc_src++;
            end
            exp_reads.push_back(ea & 16'hFFFE);
            exp_src_op = pick(ea);
        end
        if (!Ad) begin
            exp_dst_op  = bmask(dstData);
            exp_dst_ea  = 16'h0000;
            exp_dst_mem = 1'b0;
        end else begin
            exp_reads.push_back(pc);
            exp_dst_ea  = mem_rd(pc) + ((dstA == 4'd2) ? 16'h0000 : dstData);
            exp_inc_pc++;
            exp_dst_mem = 1'b1;
            if (readDst) begin
                exp_reads.push_back(exp_dst_ea & 16'hFFFE);
                exp_dst_op = pick(exp_dst_ea);
            end else begin
                exp_dst_op = 16'h0000;
            end
        end
        exp_lat = 2 + 2 * exp_reads.size();
    endtask

    // ------------------------------------------------------------------
    // Run one instruction with the current field values, acting as the
    // register file (PC) and memory, and compare every cycle.
    // ------------------------------------------------------------------
    task automatic run_instr(input bit spurious);
        int          c;
        bit          saw_done, re_now, pc_now;
        logic [15:0] rd_addr;
        model();
        got_pc = 0; got_src = 0; got_reads = 0; got_lat = 0;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = spurious;  // a start while busy must be ignored
        c = 1;
        saw_done = 1'b0;
        while (!saw_done && c <= 60) begin
            @(negedge clk);
            check("busy", busy, (c < exp_lat) ? 1 : 0);
            check("inc_overlap", incPC & incSrc, 0);
            re_now  = memRE;
            pc_now  = incPC;
            rd_addr = memAddr;
            if (memRE) begin
                got_reads++;
                if (exp_reads.size() == 0) check("extra_read", memAddr, 32'hDEAD);
                else check("memAddr", memAddr, exp_reads.pop_front());
            end
            if (incPC)  got_pc++;
            if (incSrc) got_src++;
            if (done) begin
                saw_done = 1'b1;
                got_lat  = c;
                check("latency", c, exp_lat);
                check("srcOp", srcOp, exp_src_op);
                check("dstOp", dstOp, exp_dst_op);
                check("dstEA", dstEA, exp_dst_ea);
                check("dstMem", dstMem, exp_dst_mem);
            end else begin
                @(posedge clk); #1;
                start = 1'b0;
                if (re_now) memRData = mem_rd(rd_addr);
                if (pc_now) PC = PC + 16'd2;
                c++;
            end
        end
        if (!saw_done) check("done_timeout", 0, 1);
        check("reads_left", exp_reads.size(), 0);
        check("incPC_count", got_pc, exp_inc_pc);
        check("incSrc_count", got_src, exp_inc_src);
    endtask

    task automatic set_fields(input logic ns, input logic [1:0] as_m, input logic [3:0] sa,
                              input logic ad_m, input logic [3:0] da, input logic bw_m,
                              input logic rdd, input logic [15:0] sd, input logic [15:0] dd,
                              input logic [15:0] pc_v);
        needSrc = ns; As = as_m; srcA = sa; Ad = ad_m; dstA = da; BW = bw_m;
        readDst = rdd; srcData = sd; dstData = dd; PC = pc_v;
    endtask

    initial begin
        logic [31:0] r;
        mem_salt = 16'h5A3C;
        reset = 1'b1; start = 1'b0; memRData = 16'h0000;
        set_fields(1'b1, 2'd0, 4'd5, 1'b0, 4'd6, 1'b0, 1'b0, 16'h0, 16'h0, 16'h0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_memRE", memRE, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_srcOp", srcOp, 0);
        check("rst_dstMem", dstMem, 0);
        check("rst_incPC", incPC, 0);
        @(posedge clk); #1 reset = 1'b0;

        // MOV R5, R6
        set_fields(1'b1, 2'd0, 4'd5, 1'b0, 4'd6, 1'b0, 1'b1, 16'h1234, 16'h5678, 16'hC000);
        run_instr(1'b0);
        check("mov_rr_src", srcOp, 16'h1234);
        check("mov_rr_lat", got_lat, 2);
        check("mov_rr_reads", got_reads, 0);

        // ADD #0x00AA, R4
        mem_ovr[32'hC000] = 16'h00AA;
        set_fields(1'b1, 2'd3, 4'd0, 1'b0, 4'd4, 1'b0, 1'b1, 16'h0, 16'h0011, 16'hC000);
        run_instr(1'b0);
        check("imm_src", srcOp, 16'h00AA);
        check("imm_incpc", got_pc, 1);
        check("imm_lat", got_lat, 4);

        // MOV.B @R7+, R8
        mem_ovr[32'h2000] = 16'hBEEF;
        set_fields(1'b1, 2'd3, 4'd7, 1'b0, 4'd8, 1'b1, 1'b0, 16'h2001, 16'h0000, 16'hC100);
        run_instr(1'b1);
        check("autoinc_src", srcOp, 16'h00BE);
        check("autoinc_incsrc", got_src, 1);

        // ADD 4(R9), 2(R10)
        mem_ovr[32'hE000] = 16'h0004; mem_ovr[32'hE002] = 16'h0002;
        mem_ovr[32'h3004] = 16'h1111; mem_ovr[32'h4002] = 16'h2222;
        set_fields(1'b1, 2'd1, 4'd9, 1'b1, 4'd10, 1'b0, 1'b1, 16'h3000, 16'h4000, 16'hE000);
        run_instr(1'b0);
        check("idx_dstEA", dstEA, 16'h4002);
        check("idx_dstMem", dstMem, 1);
        check("idx_incpc", got_pc, 2);
        check("idx_ops", {srcOp, dstOp}, 32'h1111_2222);
        check("idx_lat", got_lat, 10);

        // MOV #-1, &0x0200
        mem_ovr[32'hE100] = 16'h0200;
        set_fields(1'b1, 2'd3, 4'd3, 1'b1, 4'd2, 1'b0, 1'b0, 16'h0000, 16'h1234, 16'hE100);
        run_instr(1'b0);
        check("abs_src", srcOp, 16'hFFFF);
        check("abs_dstEA", dstEA, 16'h0200);
        check("abs_reads", got_reads, 1);

        // Indexed address wrap: 0xFFFE + 4 = 0x0002
        mem_ovr[32'hE200] = 16'h0004; mem_ovr[32'h0002] = 16'h7777;
        set_fields(1'b1, 2'd1, 4'd5, 1'b0, 4'd6, 1'b0, 1'b0, 16'hFFFE, 16'h0001, 16'hE200);
        run_instr(1'b0);
        check("wrap_src", srcOp, 16'h7777);

        // Reset during S_RDW of @R7+
        set_fields(1'b1, 2'd3, 4'd7, 1'b0, 4'd8, 1'b0, 1'b0, 16'h2000, 16'h0000, 16'hC100);
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;     // cycle 1: read strobe
        @(negedge clk);
        check("rstseq_rd", memRE, 1);
        @(posedge clk); #1 reset = 1'b1;     // cycle 2: capture cycle
        memRData = mem_rd(16'h2000);
        @(negedge clk);
        check("rstseq_incsrc", incSrc, 0);
        check("rstseq_incpc", incPC, 0);
        @(posedge clk); #1 reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rstseq_busy", busy, 0);
            check("rstseq_done", done, 0);
            check("rstseq_memRE", memRE, 0);
        end
        check("rstseq_srcOp", srcOp, 0);

        // Randomized instructions
        for (int n = 0; n < 200; n++) begin
            r = $urandom();
            As      = 2'(r[1:0]);
            Ad      = r[2];
            BW      = r[3];
            needSrc = (r[7:4] != 4'd0);
            readDst = r[8];
            if (As == 2'd3 && r[10:9] == 2'd0) srcA = 4'd0;
            else srcA = 4'($urandom_range(1, 15));
            dstA    = 4'($urandom_range(1, 15));
            r = $urandom();
            srcData = r[15:0];
            dstData = r[31:16];
            r = $urandom();
            PC = r[15:0] & 16'hFFFE;
            run_instr(r[16]);
            if (r[17]) begin
                @(posedge clk); #1;
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_operand_sequencer
`default_nettype wire
